// File: rtl/gru_seq_driver.sv
// Sequence controller for the d=5, h=3 fixed-point GRU cell: assembles feature
// vectors from a beat stream, feeds y back to h each timestep, streams out final h.
module gru_seq_driver #(
    parameter int INT_WIDTH  = 4,
    parameter int FRAC_WIDTH = 5,
    parameter int WIDTH      = INT_WIDTH + FRAC_WIDTH,
    parameter int LEN_WIDTH  = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic [LEN_WIDTH-1:0] seq_len,
    input  logic [WIDTH-1:0]     h_init_0,
    input  logic [WIDTH-1:0]     h_init_1,
    input  logic [WIDTH-1:0]     h_init_2,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WIDTH-1:0]     in_data,
    output logic [WIDTH-1:0]     x_0,
    output logic [WIDTH-1:0]     x_1,
    output logic [WIDTH-1:0]     x_2,
    output logic [WIDTH-1:0]     x_3,
    output logic [WIDTH-1:0]     x_4,
    output logic [WIDTH-1:0]     h_0,
    output logic [WIDTH-1:0]     h_1,
    output logic [WIDTH-1:0]     h_2,
    input  logic [WIDTH-1:0]     y_0,
    input  logic [WIDTH-1:0]     y_1,
    input  logic [WIDTH-1:0]     y_2,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [WIDTH-1:0]     out_data,
    output logic                 out_last,
    output logic                 busy,
    output logic                 done
);

    // Handshakes: a beat transfers on a rising edge where valid and ready are both
    // high; valid never waits on ready, and in_ready/out_valid are mutually exclusive.
    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_LOAD    = 3'd1,
        S_WAIT    = 3'd2,
        S_CAPTURE = 3'd3,
        S_EMIT    = 3'd4
    } state_e;

    state_e                state_q, state_d;
    logic [2:0]            idx_q, idx_d;
    logic [1:0]            oidx_q, oidx_d;
    logic [LEN_WIDTH-1:0]  t_q, t_d;
    logic [LEN_WIDTH-1:0]  len_q, len_d;
    logic [WIDTH-1:0]      x_q [5];
    logic [WIDTH-1:0]      x_d [5];
    logic [WIDTH-1:0]      h_q [3];
    logic [WIDTH-1:0]      h_d [3];
    logic                  done_q, done_d;
    logic [LEN_WIDTH:0]    t_inc;

    // One extra bit so a full-length run (len = all ones) cannot wrap early.
    assign t_inc = {1'b0, t_q} + (LEN_WIDTH + 1)'(1);

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            idx_q   <= '0;
            oidx_q  <= '0;
            t_q     <= '0;
            len_q   <= '0;
            done_q  <= 1'b0;
            for (int i = 0; i < 5; i++) x_q[i] <= '0;
            for (int i = 0; i < 3; i++) h_q[i] <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            oidx_q  <= oidx_d;
            t_q     <= t_d;
            len_q   <= len_d;
            done_q  <= done_d;
            for (int i = 0; i < 5; i++) x_q[i] <= x_d[i];
            for (int i = 0; i < 3; i++) h_q[i] <= h_d[i];
        end
    end

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        oidx_d  = oidx_q;
        t_d     = t_q;
        len_d   = len_q;
        done_d  = 1'b0;
        for (int i = 0; i < 5; i++) x_d[i] = x_q[i];
        for (int i = 0; i < 3; i++) h_d[i] = h_q[i];
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    len_d   = seq_len;
                    h_d[0]  = h_init_0;
                    h_d[1]  = h_init_1;
                    h_d[2]  = h_init_2;
                    t_d     = '0;
                    idx_d   = '0;
                    oidx_d  = '0;
                    state_d = (seq_len != '0) ? S_LOAD : S_EMIT;
                end
            end
            S_LOAD: begin
                if (in_valid) begin
                    for (int i = 0; i < 5; i++) begin
                        if (idx_q == 3'(i)) x_d[i] = in_data;
                    end
                    if (idx_q == 3'd4) begin
                        idx_d   = '0;
                        state_d = S_WAIT;
                    end else begin
                        idx_d = idx_q + 3'd1;
                    end
                end
            end
            S_WAIT: state_d = S_CAPTURE;
            S_CAPTURE: begin
                h_d[0]  = y_0;
                h_d[1]  = y_1;
                h_d[2]  = y_2;
                t_d     = t_inc[LEN_WIDTH-1:0];
                state_d = (t_inc == {1'b0, len_q}) ? S_EMIT : S_LOAD;
            end
            S_EMIT: begin
                if (out_ready) begin
                    if (oidx_q == 2'd2) begin
                        oidx_d  = '0;
                        done_d  = 1'b1;
                        state_d = S_IDLE;
                    end else begin
                        oidx_d = oidx_q + 2'd1;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        in_ready  = (state_q == S_LOAD);
        out_valid = (state_q == S_EMIT);
        out_last  = (state_q == S_EMIT) && (oidx_q == 2'd2);
        busy      = (state_q != S_IDLE);
        done      = done_q;
        out_data  = '0;
        if (state_q == S_EMIT) begin
            case (oidx_q)
                2'd0:    out_data = h_q[0];
                2'd1:    out_data = h_q[1];
                default: out_data = h_q[2];
            endcase
        end
    end

    assign x_0 = x_q[0];
    assign x_1 = x_q[1];
    assign x_2 = x_q[2];
    assign x_3 = x_q[3];
    assign x_4 = x_q[4];
    assign h_0 = h_q[0];
    assign h_1 = h_q[1];
    assign h_2 = h_q[2];

endmodule
